// File: rtl/timer_irq_master.sv
// timer_irq_master: Avalon-MM initiator that programs an interval timer
// slave (period, continuous mode, interrupt enable), services each irq by
// clearing the status register, then snapshots and reads back the live
// counter so user logic can observe service latency.
//
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   start, period_in    - (re)start request with new period, honoured in IDLE
//   stop                - stop request, honoured while waiting for irq
//   avm_*               - Avalon-MM master to timer s1 (no waitrequest)
//   irq                 - timer interrupt level
//   running             - timer has been started and not yet stopped
//   tick, tick_count    - per-service pulse and wrapping service counter
//   snapshot, snap_valid- counter captured on last service, update pulse
module timer_irq_master #(
  parameter bit          AUTO_START = 1'b1,
  parameter logic [31:0] PERIOD     = 32'd49999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] period_in,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  input  logic        irq,
  output logic        running,
  output logic        tick,
  output logic [31:0] tick_count,
  output logic [31:0] snapshot,
  output logic        snap_valid
);

  localparam logic [2:0]  REG_STATUS = 3'd0;
  localparam logic [2:0]  REG_CTRL   = 3'd1;
  localparam logic [2:0]  REG_PERL   = 3'd2;
  localparam logic [2:0]  REG_PERH   = 3'd3;
  localparam logic [2:0]  REG_SNAPL  = 3'd4;
  localparam logic [2:0]  REG_SNAPH  = 3'd5;
  localparam logic [15:0] CTRL_RUN   = 16'h0007;  // ITO | CONT | START
  localparam logic [15:0] CTRL_STOP  = 16'h0008;

  typedef enum logic [3:0] {
    S_IDLE, S_PL, S_PH, S_CTL, S_WAIT, S_CLR, S_SNP, S_RDL, S_RDH, S_CAP, S_STP
  } state_t;

  state_t      state;
  logic        auto_pend;   // one-shot auto-start request armed by reset
  logic [31:0] period_q;
  logic [15:0] snap_lo;     // low half held so snapshot updates atomically

  // Sequencer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      auto_pend  <= AUTO_START;
      period_q   <= '0;
      snap_lo    <= '0;
      running    <= 1'b0;
      tick_count <= '0;
      snapshot   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (auto_pend) begin
            period_q  <= PERIOD;
            auto_pend <= 1'b0;
            state     <= S_PL;
          end else if (start) begin
            period_q <= period_in;
            state    <= S_PL;
          end
        end
        S_PL:  state <= S_PH;
        S_PH:  state <= S_CTL;
        S_CTL: begin
          running <= 1'b1;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          // stop has priority; a held irq is picked up after restart
          if (stop)     state <= S_STP;
          else if (irq) state <= S_CLR;
        end
        S_CLR: begin
          tick_count <= tick_count + 32'd1;
          state      <= S_SNP;
        end
        S_SNP: state <= S_RDL;
        S_RDL: state <= S_RDH;
        S_RDH: begin
          snap_lo <= avm_readdata;
          state   <= S_CAP;
        end
        S_CAP: begin
          snapshot <= {avm_readdata, snap_lo};
          state    <= S_WAIT;
        end
        S_STP: begin
          running <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus strobes and pulses decoded from the state register
  always_comb begin
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = '0;
    avm_writedata  = '0;
    tick           = 1'b0;
    snap_valid     = 1'b0;
    case (state)
      S_PL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_PERL;
        avm_writedata  = period_q[15:0];
      end
      S_PH: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_PERH;
        avm_writedata  = period_q[31:16];
      end
      S_CTL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_CTRL;
        avm_writedata  = CTRL_RUN;
      end
      S_CLR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_STATUS;
        tick           = 1'b1;
      end
      S_SNP: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_SNAPL;
      end
      S_RDL: begin
        avm_chipselect = 1'b1;
        avm_address    = REG_SNAPL;
      end
      S_RDH: begin
        avm_chipselect = 1'b1;
        avm_address    = REG_SNAPH;
      end
      S_CAP: snap_valid = 1'b1;
      S_STP: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_CTRL;
        avm_writedata  = CTRL_STOP;
      end
      default: ;
    endcase
  end

endmodule
